// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: IEEE 1149.1 style data-register bank (BYPASS, IDCODE, USER).
// Selects a DR from the latched instruction and drives dr_tdo on falling tck.
//
// Ports:
//   tck, trst_n      test clock, async active-low reset
//   tap_reset        sync reset from Test-Logic-Reset
//   ir_value/update  parallel instruction and its load strobe
//   dr_capture/shift capture and shift levels from the TAP
//   dr_update        Update-DR strobe
//   tdi, dr_tdo      serial in / serial out of the selected DR
//   user_in          parallel value captured into USER
//   user_out         latched USER value, user_update pulses after it changes
module jtag_dr_bank #(
  parameter int unsigned          IR_WIDTH     = 8,
  parameter int unsigned          USER_WIDTH   = 8,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1234_5001,
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE    = IR_WIDTH'(8'h01),
  parameter logic [IR_WIDTH-1:0]  OP_USER      = IR_WIDTH'(8'h02),
  parameter logic [IR_WIDTH-1:0]  OP_BYPASS    = '1
) (
  input  logic                  tck,
  input  logic                  trst_n,
  input  logic                  tap_reset,
  input  logic [IR_WIDTH-1:0]   ir_value,
  input  logic                  ir_update,
  input  logic                  dr_capture,
  input  logic                  dr_shift,
  input  logic                  dr_update,
  input  logic                  tdi,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic                  dr_tdo,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  user_update
);

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } sel_t;

  // Bit 0 of an IDCODE is always 1 so a debugger can tell it from BYPASS.
  localparam logic [31:0] ID_CAP = {IDCODE_VALUE[31:1], 1'b1};

  sel_t                  sel_q, sel_d, sel_dec;
  logic                  byp_q, byp_d;
  logic [31:0]           id_q, id_d;
  logic [USER_WIDTH-1:0] usr_q, usr_d;
  logic [USER_WIDTH-1:0] out_q, out_d;
  logic                  upd_q, upd_d;
  logic                  tdo_q, tdo_d;

  always_comb begin
    sel_dec = SEL_BYPASS;
    unique case (1'b1)
      (ir_value == OP_IDCODE): sel_dec = SEL_IDCODE;
      (ir_value == OP_USER):   sel_dec = SEL_USER;
      (ir_value == OP_BYPASS): sel_dec = SEL_BYPASS;
      default:                 sel_dec = SEL_BYPASS;
    endcase
  end

  // DR actions use sel_q, so an instruction loaded on the same
  // edge only takes effect from the following edge.
  always_comb begin
    sel_d = sel_q;
    byp_d = byp_q;
    id_d  = id_q;
    usr_d = usr_q;
    out_d = out_q;
    upd_d = 1'b0;

    if (ir_update) sel_d = sel_dec;

    if (dr_capture) begin
      unique case (sel_q)
        SEL_BYPASS: byp_d = 1'b0;
        SEL_IDCODE: id_d  = ID_CAP;
        SEL_USER:   usr_d = user_in;
        default:    ;
      endcase
    end else if (dr_shift) begin
      unique case (sel_q)
        SEL_BYPASS: byp_d = tdi;
        SEL_IDCODE: id_d  = {tdi, id_q[31:1]};
        SEL_USER:   usr_d = {tdi, usr_q[USER_WIDTH-1:1]};
        default:    ;
      endcase
    end

    if (dr_update && (sel_q == SEL_USER)) begin
      out_d = usr_q;
      upd_d = 1'b1;
    end

    if (tap_reset) begin
      sel_d = SEL_IDCODE;
      byp_d = 1'b0;
      id_d  = '0;
      usr_d = '0;
      out_d = '0;
      upd_d = 1'b0;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      sel_q <= SEL_IDCODE;
      byp_q <= 1'b0;
      id_q  <= '0;
      usr_q <= '0;
      out_q <= '0;
      upd_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      byp_q <= byp_d;
      id_q  <= id_d;
      usr_q <= usr_d;
      out_q <= out_d;
      upd_q <= upd_d;
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    unique case (sel_q)
      SEL_BYPASS: tdo_d = byp_q;
      SEL_IDCODE: tdo_d = id_q[0];
      SEL_USER:   tdo_d = usr_q[0];
      default:    tdo_d = 1'b0;
    endcase
  end

  // TDO changes on falling tck so it is stable for the next rising edge.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) tdo_q <= 1'b0;
    else         tdo_q <= tdo_d;
  end

  assign dr_tdo      = tdo_q;
  assign user_out    = out_q;
  assign user_update = upd_q;

endmodule
